// File: rtl/cla2_stage32_pkg.sv
// Shared constants and carry-lookahead helpers for the two-stage 32-bit adder.
// The lookahead helpers are written for 4-bit groups (GROUP_W == 4).
package cla2_stage32_pkg;

    localparam int WIDTH      = 32;
    localparam int HALF_W     = 16;
    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = HALF_W / GROUP_W;

    // Carries into positions 0..3 of a 4-wide block, fully flattened so no
    // carry ripples from one position to the next.
    function automatic logic [GROUP_W-1:0] lookahead_carries(
        input logic [GROUP_W-1:0] p,
        input logic [GROUP_W-1:0] g,
        input logic               cin
    );
        logic [GROUP_W-1:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    // Block generate: the 4-wide block produces a carry on its own.
    function automatic logic group_generate(
        input logic [GROUP_W-1:0] p,
        input logic [GROUP_W-1:0] g
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla2_stage32_cla16.sv
// 16-bit two-level carry-lookahead adder: bit-level P/G feed 4-bit groups,
// group P/G feed a second lookahead that yields c4/c8/c12/c16 directly.
module cla16
    import cla2_stage32_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] sum,
    output logic              cout
);

    logic [HALF_W-1:0]     w_p;
    logic [HALF_W-1:0]     w_g;
    logic [HALF_W-1:0]     w_bitCarry;
    logic [NUM_GROUPS-1:0] w_grpP;
    logic [NUM_GROUPS-1:0] w_grpG;
    logic [NUM_GROUPS-1:0] w_grpCarry;

    assign w_p = a ^ b;
    assign w_g = a & b;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_group
        assign w_grpP[k] = &w_p[k*GROUP_W +: GROUP_W];
        assign w_grpG[k] = group_generate(w_p[k*GROUP_W +: GROUP_W], w_g[k*GROUP_W +: GROUP_W]);
        assign w_bitCarry[k*GROUP_W +: GROUP_W] =
            lookahead_carries(w_p[k*GROUP_W +: GROUP_W], w_g[k*GROUP_W +: GROUP_W], w_grpCarry[k]);
    end

    // Second lookahead level: group carries c0, c4, c8, c12 from group P/G.
    assign w_grpCarry = lookahead_carries(w_grpP, w_grpG, cin);

    // c16 from the group terms, never from the c12 group's internal carries.
    assign cout = group_generate(w_grpP, w_grpG) | ((&w_grpP) & cin);

    assign sum = w_p ^ w_bitCarry;

endmodule

// File: rtl/cla2_stage32.sv
// Two-stage pipelined 32-bit adder producing a registered 33-bit sum.
// Stage 1 adds the low halves and registers the high operands with c16;
// stage 2 adds the high halves using the registered c16 as carry-in.
// Optional macro CLA2_STAGE32_VALID_EN adds in_valid/out_valid; out_sum then
// only updates for valid operand pairs.
module cla2_stage32
    import cla2_stage32_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef CLA2_STAGE32_VALID_EN
    input  logic             in_valid,
    output logic             out_valid,
`endif
    output logic [WIDTH:0]   out_sum
);

    logic [HALF_W-1:0] w_lowSum;
    logic              w_lowCout;
    logic [HALF_W-1:0] w_highSum;
    logic              w_highCout;

    logic [HALF_W-1:0] r_lowSum;
    logic              r_c16;
    logic [HALF_W-1:0] r_aHi;
    logic [HALF_W-1:0] r_bHi;
    logic [WIDTH:0]    r_sum;

    cla16 u_lowCla (
        .a    (in_a[HALF_W-1:0]),
        .b    (in_b[HALF_W-1:0]),
        .cin  (1'b0),
        .sum  (w_lowSum),
        .cout (w_lowCout)
    );

    // Stage 1: capture the low half result, c16 and the untouched high operands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lowSum <= '0;
            r_c16    <= 1'b0;
            r_aHi    <= '0;
            r_bHi    <= '0;
        end else begin
            r_lowSum <= w_lowSum;
            r_c16    <= w_lowCout;
            r_aHi    <= in_a[WIDTH-1:HALF_W];
            r_bHi    <= in_b[WIDTH-1:HALF_W];
        end
    end

    cla16 u_highCla (
        .a    (r_aHi),
        .b    (r_bHi),
        .cin  (r_c16),
        .sum  (w_highSum),
        .cout (w_highCout)
    );

`ifdef CLA2_STAGE32_VALID_EN
    logic r_valid1;
    logic r_valid2;

    // Valid pipeline tracking which operand pair occupies each stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
        end else begin
            r_valid1 <= in_valid;
            r_valid2 <= r_valid1;
        end
    end

    assign out_valid = r_valid2;

    // Stage 2: register the full sum only for a valid pair, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (r_valid1) begin
            r_sum <= {w_highCout, w_highSum, r_lowSum};
        end
    end
`else
    // Stage 2: register carry-out, high half and the delayed low half.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else begin
            r_sum <= {w_highCout, w_highSum, r_lowSum};
        end
    end
`endif

    assign out_sum = r_sum;

endmodule

// File: tb/tb_cla2_stage32.sv
// Bench for cla2_stage32: a two-deep reference pipeline of plain 33-bit sums
// is compared with out_sum on every falling edge, plus literal corner cases.
module tb_cla2_stage32;

    logic        clock;
    logic        reset;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [32:0] out_sum;

    logic [32:0] mStage;
    logic [32:0] mOut;
    logic        checkEn;
    int          checkCount;
    int          passCount;

    cla2_stage32 dut (
        .clock   (clock),
        .reset   (reset),
        .in_a    (in_a),
        .in_b    (in_b),
        .out_sum (out_sum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the sum sampled at one edge appears one edge later; reset empties it.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mStage <= '0;
            mOut   <= '0;
        end else begin
            mOut   <= mStage;
            mStage <= {1'b0, in_a} + {1'b0, in_b};
        end
    end

    // Every falling edge, the DUT must match the reference.
    always @(negedge clock) begin
        if (checkEn) begin
            checkCount++;
            if (out_sum === mOut) passCount++;
            else $display("[TB] FAIL pipeCompare t=%0t out_sum=%h expected=%h", $time, out_sum, mOut);
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #1;
        in_a = a;
        in_b = b;
    endtask

    task automatic checkOutput(input string name, input logic [32:0] expected);
        checkCount++;
        if (out_sum === expected) passCount++;
        else $display("[TB] FAIL %s dut out_sum=%h expected=%h", name, out_sum, expected);
        checkCount++;
        if (mOut === expected) passCount++;
        else $display("[TB] FAIL %s model=%h expected=%h", name, mOut, expected);
    endtask

    task automatic singleCase(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [32:0] expected);
        applyStimulus(a, b);
        repeat (2) @(posedge clock);
        #2;
        checkOutput(name, expected);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        checkCount = 0;
        passCount  = 0;
        checkEn    = 1'b0;
        reset      = 1'b0;
        in_a       = 32'h1234_5678;
        in_b       = 32'h9ABC_DEF0;

        repeat (3) @(posedge clock);
        #2;
        checkOutput("resetState", 33'h0);
        checkEn = 1'b1;
        @(negedge clock);
        #2;
        reset = 1'b1;

        singleCase("carryOut",    32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        singleCase("c16Boundary", 32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000);
        singleCase("allOnes",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
        singleCase("zeros",       32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000);

        applyStimulus(32'h0000_0001, 32'h0000_0002);
        applyStimulus(32'h8000_0000, 32'h8000_0000);
        @(posedge clock);
        #2;
        checkOutput("backToBack0", 33'h0_0000_0003);
        @(posedge clock);
        #2;
        checkOutput("backToBack1", 33'h1_0000_0000);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 3))
                0: ra[15:0] = 16'hFFFF;
                1: begin ra = ~rb; end
                default: ;
            endcase
            applyStimulus(ra, rb);

            if (i == 500) begin
                applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
                repeat (2) @(posedge clock);
                #3;
                checkOutput("preReset", 33'h1_FFFF_FFFE);
                reset = 1'b0;
                #1;
                checkOutput("asyncClear", 33'h0);
                for (int j = 0; j < 3; j++) begin
                    applyStimulus($urandom(), $urandom());
                end
                #2;
                checkOutput("heldInReset", 33'h0);
                @(negedge clock);
                #2;
                reset = 1'b1;
                applyStimulus(32'h0000_FFFF, 32'h0000_0001);
                #1;
                checkOutput("firstAfterRelease", 33'h0);
                repeat (2) @(posedge clock);
                #2;
                checkOutput("resumeAfterReset", 33'h0_0001_0000);
            end
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cla2_stage32.md
CLA2_STAGE32 -- requirements
Module: cla2_stage32

Interface
- REQ-001: Parameters: none; operand width fixed at 32 bits via package constants.
- REQ-002: clock  input  1  sole clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: in_a  input  32  unsigned operand A, sampled every rising edge.
- REQ-005: in_b  input  32  unsigned operand B, sampled every rising edge.
- REQ-006: out_sum  output  33  registered unsigned sum; bit 32 = carry-out.

Function
- REQ-007: out_sum SHALL equal the full 33-bit sum in_a + in_b, with no overflow loss and no carry-in.
- REQ-008: Stage 1 (combinational from inputs) SHALL compute bits [15:0] with a 16-bit two-level CLA (4-bit groups, group P/G, lookahead carries c4/c8/c12/c16).
- REQ-009: At edge N, stage-1 registers SHALL capture low sum[15:0], c16, in_a[31:16] and in_b[31:16].
- REQ-010: Stage 2 SHALL compute bits [31:16] and carry-out with an identical 16-bit CLA, using registered c16 as carry-in.
- REQ-011: At edge N+1, out_sum SHALL be registered as {cout, high sum, low sum}.
- REQ-012: Latency SHALL be exactly 2 rising edges from input sampling to out_sum update; throughput one new operand pair per cycle, no stalls.
- REQ-013: No combinational path SHALL exist from in_a/in_b to out_sum.
- REQ-014: The carry chain SHALL contain no 32-bit ripple path; critical path SHALL be one 16-bit CLA per stage.
- REQ-015: Input changes between edges SHALL NOT affect out_sum until propagated through both stages.

Reset
- REQ-016: reset low SHALL immediately, without a clock, clear all pipeline registers and drive out_sum to 33'h0.
- REQ-017: Reset asserted mid-operation SHALL discard in-flight operands; after release, the first valid out_sum appears 2 edges after the first sampled input.
- REQ-018: While reset is low, out_sum SHALL hold 0 regardless of clock or inputs.

Configuration
- REQ-019: Macro CLA2_STAGE32_VALID_EN, when defined, SHALL add input in_valid (1 bit) and output out_valid (1 bit).
- REQ-020: With CLA2_STAGE32_VALID_EN, out_valid SHALL equal in_valid delayed 2 edges, reset to 0; out_sum SHALL update only when the corresponding valid is high, otherwise holding its value.
- REQ-021: Without CLA2_STAGE32_VALID_EN, these ports SHALL be absent and every cycle is valid.

Structure
- REQ-022: Package cla2_stage32_pkg SHALL hold WIDTH=32, HALF_W=16, GROUP_W=4.
- REQ-023: Sub-module cla16 (16-bit two-level CLA: a, b, cin -> sum[15:0], cout) SHALL be instantiated once per stage.

Verification
- REQ-024: Assert reset low mid-stream with nonzero out_sum -> out_sum becomes 33'h0 before the next edge.
- REQ-025: in_a=32'hFFFFFFFF, in_b=32'h00000001 -> out_sum=33'h1_00000000 after 2 edges.
- REQ-026: in_a=32'h0000FFFF, in_b=32'h00000001 -> out_sum=33'h0_00010000 (c16 crosses the stage boundary).
- REQ-027: in_a=in_b=32'hFFFFFFFF -> out_sum=33'h1_FFFFFFFE.
- REQ-028: Back-to-back pairs (1,2), then (32'h80000000, 32'h80000000) -> out_sum=3, then 33'h1_00000000 on consecutive cycles.
- REQ-029: 1000 random pairs, one per cycle -> each out_sum equals the 33-bit in_a+in_b from 2 edges earlier; zero mismatches.
